elevator_unit: RTL and testbench

Sequential executor for one elevator car in the elevator simulator. Each `step` it consumes the per-car `hold` and `turn` decision produced by the combinational turn-decision stage and applies it: alights arrived passengers, boards waiting passengers, then moves or reverses the car. It owns the car's floor, direction and boarding slots, which feed back into the turn-decision stage. It reports picked-up requests so the passenger table can clear them.

---
 rtl/elevator_unit_if.sv | 29 ++
 rtl/elevator_unit.sv | 206 ++++++++++++++++++++
 tb/tb_elevator_unit.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/elevator_unit_if.sv
// Handshake and status bundle between the turn-decision stage and one
// elevator car executor.
interface elevator_unit_if;
    logic       step;
    logic [6:0] hold;
    logic       turn;
    logic [5:0] dest;
    logic [2:0] curr_floor;
    logic       dir;
    logic [5:0] boarding;
    logic [1:0] pick;
    logic [7:0] delivered;
    logic       busy;
    logic       step_done;
    logic       finished;
    logic       err;

    modport master (
        output step, hold, turn, dest,
        input  curr_floor, dir, boarding, pick, delivered,
        input  busy, step_done, finished, err
    );

    modport slave (
        input  step, hold, turn, dest,
        output curr_floor, dir, boarding, pick, delivered,
        output busy, step_done, finished, err
    );
endinterface

// File: rtl/elevator_unit.sv
// Sequential executor for one elevator car: applies the per-turn decision
// (alight, board, move/reverse) and owns the car's floor, direction and slots.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for step; car state stable for the decision stage
// S_ALIGHT | clear slots whose destination is the current floor
// S_BOARD  | place waiting passengers into empty slots, pulse pick
// S_MOVE   | move one floor or reverse, pulse step_done
// S_FINISH | simulation ended; only reset leaves this state
module elevator_unit #(
    parameter int INIT_FLOOR = 1,
    parameter int INIT_DIR   = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    elevator_unit_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGHT,
        S_BOARD,
        S_MOVE,
        S_FINISH
    } state_t;

    localparam logic [2:0] RST_FLOOR = 3'(INIT_FLOOR);
    localparam logic       RST_DIR   = 1'(INIT_DIR);

    state_t     state_q, state_n;

    // Decision latched at step acceptance; the inputs may change afterwards.
    logic [1:0] leaval_q, leaval_n;
    logic       board_q, board_n;
    logic       turn_q, turn_n;
    logic [5:0] dest_q, dest_n;

    logic [2:0] floor_q, floor_n;
    logic       dir_q, dir_n;
    logic [2:0] slot0_q, slot0_n;
    logic [2:0] slot1_q, slot1_n;
    logic [7:0] deliv_q, deliv_n;
    logic [1:0] pick_q, pick_n;
    logic       err_q, err_n;
    logic       step_done_q, step_done_n;
    logic       busy_q, busy_n;
    logic       finished_q, finished_n;

    logic [1:0] cleared;
    logic [2:0] pass_dest;

    // The spare-slot count is informational only; board-enable already
    // encodes whether boarding is possible.
    logic       spare_unused;
    assign spare_unused = ^bus.hold[4:3];

    // Next-state and next-output logic for the turn sequencer.
    always_comb begin
        state_n     = state_q;
        leaval_n    = leaval_q;
        board_n     = board_q;
        turn_n      = turn_q;
        dest_n      = dest_q;
        floor_n     = floor_q;
        dir_n       = dir_q;
        slot0_n     = slot0_q;
        slot1_n     = slot1_q;
        deliv_n     = deliv_q;
        err_n       = err_q;
        pick_n      = 2'b00;
        step_done_n = 1'b0;
        cleared     = 2'd0;
        pass_dest   = 3'd0;

        case (state_q)
            S_IDLE: begin
                if (bus.step) begin
                    leaval_n = bus.hold[1:0];
                    board_n  = bus.hold[2];
                    turn_n   = bus.turn;
                    dest_n   = bus.dest;
                    if (bus.hold[6]) begin
                        state_n = S_FINISH;
                    end else if (bus.hold[5]) begin
                        state_n = S_ALIGHT;
                    end else if (bus.hold[2]) begin
                        state_n = S_BOARD;
                    end else begin
                        state_n = S_MOVE;
                    end
                end
            end

            S_ALIGHT: begin
                // Floors are 1..7, so an empty slot (0) never matches.
                if (slot0_q == floor_q) begin
                    slot0_n = 3'd0;
                    cleared = cleared + 2'd1;
                end
                if (slot1_q == floor_q) begin
                    slot1_n = 3'd0;
                    cleared = cleared + 2'd1;
                end
                if (deliv_q > (8'd255 - {6'd0, cleared})) begin
                    deliv_n = 8'd255;
                end else begin
                    deliv_n = deliv_q + {6'd0, cleared};
                end
                state_n = board_q ? S_BOARD : S_MOVE;
            end

            S_BOARD: begin
                // Passengers are picked even when they cannot be placed, so
                // the request table never holds a stale entry.
                for (int i = 0; i < 2; i++) begin
                    if (leaval_q[i]) begin
                        pass_dest = dest_q[3*i +: 3];
                        if (pass_dest == 3'd0 || pass_dest == floor_q) begin
                            err_n = 1'b1;
                        end else if (slot0_n == 3'd0) begin
                            slot0_n = pass_dest;
                        end else if (slot1_n == 3'd0) begin
                            slot1_n = pass_dest;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end
                pick_n  = leaval_q;
                state_n = S_MOVE;
            end

            S_MOVE: begin
                if (turn_q || (dir_q && floor_q == 3'd7) || (!dir_q && floor_q == 3'd1)) begin
                    dir_n = ~dir_q;
                end else if (dir_q) begin
                    floor_n = floor_q + 3'd1;
                end else begin
                    floor_n = floor_q - 3'd1;
                end
                step_done_n = 1'b1;
                state_n     = S_IDLE;
            end

            S_FINISH: begin
                state_n = S_FINISH;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase

        busy_n     = (state_n != S_IDLE) && (state_n != S_FINISH);
        finished_n = (state_n == S_FINISH);
    end

    // State and registered outputs; reset aborts any turn in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            leaval_q    <= 2'b00;
            board_q     <= 1'b0;
            turn_q      <= 1'b0;
            dest_q      <= 6'd0;
            floor_q     <= RST_FLOOR;
            dir_q       <= RST_DIR;
            slot0_q     <= 3'd0;
            slot1_q     <= 3'd0;
            deliv_q     <= 8'd0;
            pick_q      <= 2'b00;
            err_q       <= 1'b0;
            step_done_q <= 1'b0;
            busy_q      <= 1'b0;
            finished_q  <= 1'b0;
        end else begin
            state_q     <= state_n;
            leaval_q    <= leaval_n;
            board_q     <= board_n;
            turn_q      <= turn_n;
            dest_q      <= dest_n;
            floor_q     <= floor_n;
            dir_q       <= dir_n;
            slot0_q     <= slot0_n;
            slot1_q     <= slot1_n;
            deliv_q     <= deliv_n;
            pick_q      <= pick_n;
            err_q       <= err_n;
            step_done_q <= step_done_n;
            busy_q      <= busy_n;
            finished_q  <= finished_n;
        end
    end

    assign bus.curr_floor = floor_q;
    assign bus.dir        = dir_q;
    assign bus.boarding   = {slot1_q, slot0_q};
    assign bus.pick       = pick_q;
    assign bus.delivered  = deliv_q;
    assign bus.busy       = busy_q;
    assign bus.step_done  = step_done_q;
    assign bus.finished   = finished_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_elevator_unit.sv
// Directed bench for elevator_unit with a reference model feeding a
// scoreboard queue of expected turn results.
module tb_elevator_unit;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    elevator_unit_if eu_if ();

    elevator_unit #(
        .INIT_FLOOR(1),
        .INIT_DIR  (1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (eu_if)
    );

    typedef struct {
        int         lat;
        logic [1:0] pick;
        logic [2:0] floor;
        logic       dir;
        logic [5:0] boarding;
        logic [7:0] deliv;
        logic       err;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    logic [2:0] m_floor;
    logic       m_dir;
    logic [2:0] m_s0, m_s1;
    logic [7:0] m_deliv;
    logic       m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_floor = 3'd1;
        m_dir   = 1'b1;
        m_s0    = 3'd0;
        m_s1    = 3'd0;
        m_deliv = 8'd0;
        m_err   = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_floor"}, 32'(eu_if.curr_floor), 32'd1);
        chk({tag, "_dir"}, 32'(eu_if.dir), 32'd1);
        chk({tag, "_boarding"}, 32'(eu_if.boarding), 32'd0);
        chk({tag, "_pick"}, 32'(eu_if.pick), 32'd0);
        chk({tag, "_delivered"}, 32'(eu_if.delivered), 32'd0);
        chk({tag, "_busy"}, 32'(eu_if.busy), 32'd0);
        chk({tag, "_step_done"}, 32'(eu_if.step_done), 32'd0);
        chk({tag, "_finished"}, 32'(eu_if.finished), 32'd0);
        chk({tag, "_err"}, 32'(eu_if.err), 32'd0);
    endtask

    // Called at a negedge; leaves the bench at a negedge with rst_n released.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_reset(tag);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One full turn: model the expected outcome, drive step, wait for step_done.
    task automatic do_step(input string tag, input logic [6:0] hold,
                           input logic turn, input logic [5:0] dest);
        exp_t       e;
        logic [2:0] d;
        logic [2:0] start_floor;
        logic       start_dir;
        logic [1:0] pick_seen;
        int         pick_cycles;
        logic       pick_pos_ok;
        logic       busy_mid;
        logic       done;
        int         n;

        start_floor = m_floor;
        start_dir   = m_dir;
        e.lat       = 2;
        if (hold[5]) begin
            e.lat++;
            if (m_s0 == m_floor) begin
                m_s0 = 3'd0;
                if (m_deliv != 8'd255) m_deliv++;
            end
            if (m_s1 == m_floor) begin
                m_s1 = 3'd0;
                if (m_deliv != 8'd255) m_deliv++;
            end
        end
        e.pick = 2'b00;
        if (hold[2]) begin
            e.lat++;
            e.pick = hold[1:0];
            for (int i = 0; i < 2; i++) begin
                if (hold[i]) begin
                    d = dest[3*i +: 3];
                    if (d == 3'd0 || d == m_floor) m_err = 1'b1;
                    else if (m_s0 == 3'd0) m_s0 = d;
                    else if (m_s1 == 3'd0) m_s1 = d;
                    else m_err = 1'b1;
                end
            end
        end
        if (turn || (m_dir && m_floor == 3'd7) || (!m_dir && m_floor == 3'd1)) m_dir = ~m_dir;
        else if (m_dir) m_floor = m_floor + 3'd1;
        else m_floor = m_floor - 3'd1;
        e.floor    = m_floor;
        e.dir      = m_dir;
        e.boarding = {m_s1, m_s0};
        e.deliv    = m_deliv;
        e.err      = m_err;
        sb.push_back(e);

        eu_if.step = 1'b1;
        eu_if.hold = hold;
        eu_if.turn = turn;
        eu_if.dest = dest;
        @(posedge clk);
        #1 eu_if.step = 1'b0;

        n           = 0;
        pick_seen   = 2'b00;
        pick_cycles = 0;
        pick_pos_ok = 1'b1;
        busy_mid    = 1'b0;
        done        = 1'b0;
        while (!done && n < 10) begin
            @(negedge clk);
            n++;
            if (n == 1) busy_mid = eu_if.busy;
            if (eu_if.pick != 2'b00) begin
                pick_cycles++;
                pick_seen = pick_seen | eu_if.pick;
                if (eu_if.curr_floor !== start_floor || eu_if.dir !== start_dir) pick_pos_ok = 1'b0;
            end
            if (eu_if.step_done === 1'b1) done = 1'b1;
        end

        e = sb.pop_front();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy"}, 32'(busy_mid), 32'd1);
        chk({tag, "_lat"}, 32'(n), 32'(e.lat));
        chk({tag, "_pick"}, 32'(pick_seen), 32'(e.pick));
        chk({tag, "_pick_cycles"}, 32'(pick_cycles), (e.pick != 2'b00) ? 32'd1 : 32'd0);
        chk({tag, "_pick_pos"}, 32'(pick_pos_ok), 32'd1);
        chk({tag, "_floor"}, 32'(eu_if.curr_floor), 32'(e.floor));
        chk({tag, "_dir"}, 32'(eu_if.dir), 32'(e.dir));
        chk({tag, "_boarding"}, 32'(eu_if.boarding), 32'(e.boarding));
        chk({tag, "_delivered"}, 32'(eu_if.delivered), 32'(e.deliv));
        chk({tag, "_err"}, 32'(eu_if.err), 32'(e.err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] pick_any;
        logic       sd_any;

        rst_n      = 1'b0;
        eu_if.step = 1'b0;
        eu_if.hold = 7'd0;
        eu_if.turn = 1'b0;
        eu_if.dest = 6'd0;
        @(negedge clk);

        // Plain moves to the top floor, then boundary reversal.
        do_reset("rst_a");
        for (int k = 0; k < 6; k++) do_step("move_up", 7'b0000000, 1'b0, 6'd0);
        do_step("top_rev", 7'b0000000, 1'b0, 6'd0);

        // Board two at floor 1, alight one at floor 3, turn at floor 4, finish.
        do_reset("rst_b");
        do_step("board_13", 7'b0000111, 1'b0, {3'd5, 3'd3});
        do_step("move_2", 7'b0000000, 1'b0, 6'd0);
        do_step("alight_3", 7'b0100000, 1'b0, 6'd0);
        do_step("turn_4", 7'b0000000, 1'b1, 6'd0);

        eu_if.step = 1'b1;
        eu_if.hold = 7'b1000000;
        @(posedge clk);
        #1 eu_if.step = 1'b0;
        sd_any = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (eu_if.step_done === 1'b1) sd_any = 1'b1;
        end
        chk("fin_finished", 32'(eu_if.finished), 32'd1);
        chk("fin_busy", 32'(eu_if.busy), 32'd0);
        chk("fin_no_done", 32'(sd_any), 32'd0);
        eu_if.step = 1'b1;
        eu_if.hold = 7'b0000000;
        @(posedge clk);
        #1 eu_if.step = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (eu_if.step_done === 1'b1) sd_any = 1'b1;
        end
        chk("fin_hold_floor", 32'(eu_if.curr_floor), 32'd4);
        chk("fin_hold_dir", 32'(eu_if.dir), 32'd0);
        chk("fin_still", 32'(eu_if.finished), 32'd1);
        chk("fin_busy2", 32'(eu_if.busy), 32'd0);
        chk("fin_no_done2", 32'(sd_any), 32'd0);

        // Board at floor 2, alight+board at floor 4, slot-full error at 5.
        do_reset("rst_c");
        do_step("move_1", 7'b0000000, 1'b0, 6'd0);
        do_step("board_2", 7'b0000111, 1'b0, {3'd6, 3'd4});
        do_step("move_3", 7'b0000000, 1'b0, 6'd0);
        do_step("alight_board_4", 7'b0100101, 1'b0, {3'd0, 3'd7});
        do_step("full_5", 7'b0000110, 1'b0, {3'd3, 3'd0});

        // Destination equal to the current floor.
        do_reset("rst_d");
        do_step("bad_dest", 7'b0000101, 1'b0, {3'd0, 3'd1});

        // Reset asserted while in BOARD.
        do_reset("rst_e");
        eu_if.step = 1'b1;
        eu_if.hold = 7'b0000111;
        eu_if.dest = {3'd3, 3'd2};
        @(posedge clk);
        #1 eu_if.step = 1'b0;
        chk("pre_rst_busy", 32'(eu_if.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset("rst_mid");
        pick_any = 2'b00;
        sd_any   = 1'b0;
        repeat (3) begin
            @(negedge clk);
            pick_any = pick_any | eu_if.pick;
            if (eu_if.step_done === 1'b1) sd_any = 1'b1;
        end
        chk("rst_mid_no_pick", 32'(pick_any), 32'd0);
        chk("rst_mid_no_done", 32'(sd_any), 32'd0);
        chk("rst_mid_boarding", 32'(eu_if.boarding), 32'd0);
        rst_n = 1'b1;
        model_reset();
        do_step("post_rst", 7'b0000000, 1'b0, 6'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
